reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/lc3b_types.sv | 39 +++
 rtl/rob_ptr.sv | 23 ++
 rtl/reorder_buffer.sv | 158 +++++++++++++++
 tb/tb_reorder_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types and the reorder buffer entry layout
package lc3b_types;

   localparam int rob_tag_width = 3;

   typedef logic [15:0]              lc3b_word;
   typedef logic [2:0]               lc3b_reg;
   typedef logic [rob_tag_width-1:0] lc3b_rob_addr;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   // Bookkeeping half of an entry; the result value lives in a separate
   // data_width-wide array so the value width can be parameterised.
   typedef struct packed {
      logic       occupied;
      logic       ready;
      lc3b_opcode opcode;
      lc3b_reg    dest;
      logic       predict;
   } rob_entry;

endpackage

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - modulo-depth circular buffer pointer
module rob_ptr #(
   parameter int width = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [width-1:0] ptr
);

   // Depth is a power of two, so natural overflow gives the wrap to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer; ROB_FWD_EN adds operand lookup ports
module reorder_buffer
   import lc3b_types::*;
#(
   parameter int data_width = 16,
   parameter int tag_width  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // dispatch
   input  logic                  alloc_req,
   input  lc3b_opcode            alloc_opcode,
   input  lc3b_reg               alloc_dest,
   input  logic                  alloc_predict,
   output logic [tag_width-1:0]  alloc_addr,
   output logic                  full,
   // common data bus
   input  logic                  cdb_valid,
   input  logic [tag_width-1:0]  cdb_tag,
   input  logic [data_width-1:0] cdb_value,
   // commit
   output logic                  head_valid,
   output lc3b_opcode            head_opcode,
   output lc3b_reg               head_dest,
   output logic [data_width-1:0] head_value,
   output logic                  head_predict,
   output logic [tag_width-1:0]  head_addr,
   output logic                  empty,
   input  logic                  RE,
   // control
   input  logic                  flush
`ifdef ROB_FWD_EN
   ,
   input  logic [tag_width-1:0]  rd_tag_a,
   input  logic [tag_width-1:0]  rd_tag_b,
   output logic [data_width-1:0] rd_value_a,
   output logic [data_width-1:0] rd_value_b,
   output logic                  rd_ready_a,
   output logic                  rd_ready_b
`endif
);

   localparam int depth = 2**tag_width;

   rob_entry              ent [depth];
   logic [data_width-1:0] val [depth];
   logic [tag_width:0]    count;
   logic [tag_width-1:0]  head;
   logic [tag_width-1:0]  tail;
   logic                  do_alloc;
   logic                  do_pop;
   logic                  do_cdb;

   assign empty      = (count == '0);
   assign full       = (count == (tag_width+1)'(depth));
   assign alloc_addr = tail;
   assign head_addr  = head;

   // Qualify the three update sources; flush discards them all, and a
   // CDB result aimed at the entry being popped is dropped.
   always_comb begin
      do_alloc = alloc_req && !full && !flush;
      do_pop   = RE && !empty && !flush;
      do_cdb   = cdb_valid && ent[cdb_tag].occupied && !flush
                 && !(do_pop && (cdb_tag == head));
   end

   rob_ptr #(.width(tag_width)) u_head_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .inc   (do_pop),
      .ptr   (head)
   );

   rob_ptr #(.width(tag_width)) u_tail_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .inc   (do_alloc),
      .ptr   (tail)
   );

   // Occupancy counter; simultaneous allocate and pop cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (do_alloc && !do_pop) begin
         count <= count + 1'b1;
      end else if (!do_alloc && do_pop) begin
         count <= count - 1'b1;
      end
   end

   // Entry storage: allocate at tail, CDB result capture, release at head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < depth; i++) begin
            ent[i] <= '0;
            val[i] <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < depth; i++) begin
            ent[i] <= '0;
            val[i] <= '0;
         end
      end else begin
         for (int i = 0; i < depth; i++) begin
            if (do_alloc && (tail == tag_width'(i))) begin
               ent[i].occupied <= 1'b1;
               ent[i].ready    <= 1'b0;
               ent[i].opcode   <= alloc_opcode;
               ent[i].dest     <= alloc_dest;
               ent[i].predict  <= alloc_predict;
               val[i]          <= '0;
            end
            if (do_cdb && (cdb_tag == tag_width'(i))) begin
               ent[i].ready <= 1'b1;
               val[i]       <= cdb_value;
            end
            if (do_pop && (head == tag_width'(i))) begin
               ent[i].occupied <= 1'b0;
               ent[i].ready    <= 1'b0;
            end
         end
      end
   end

   // Commit view is a plain read of the head slot.
   always_comb begin
      head_valid   = !empty && ent[head].ready;
      head_opcode  = ent[head].opcode;
      head_dest    = ent[head].dest;
      head_value   = val[head];
      head_predict = ent[head].predict;
   end

`ifdef ROB_FWD_EN
   // Operand lookup with same-cycle bypass from the CDB onto occupied entries.
   always_comb begin
      rd_value_a = val[rd_tag_a];
      rd_ready_a = ent[rd_tag_a].occupied && ent[rd_tag_a].ready;
      if (cdb_valid && (cdb_tag == rd_tag_a) && ent[rd_tag_a].occupied) begin
         rd_value_a = cdb_value;
         rd_ready_a = 1'b1;
      end
      rd_value_b = val[rd_tag_b];
      rd_ready_b = ent[rd_tag_b].occupied && ent[rd_tag_b].ready;
      if (cdb_valid && (cdb_tag == rd_tag_b) && ent[rd_tag_b].occupied) begin
         rd_value_b = cdb_value;
         rd_ready_b = 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer
module tb_reorder_buffer;
   import lc3b_types::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alloc_req;
   lc3b_opcode  alloc_opcode;
   lc3b_reg     alloc_dest;
   logic        alloc_predict;
   logic [2:0]  alloc_addr;
   logic        full;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_value;
   logic        head_valid;
   lc3b_opcode  head_opcode;
   lc3b_reg     head_dest;
   logic [15:0] head_value;
   logic        head_predict;
   logic [2:0]  head_addr;
   logic        empty;
   logic        RE;
   logic        flush;
`ifdef ROB_FWD_EN
   logic [2:0]  rd_tag_a;
   logic [2:0]  rd_tag_b;
   logic [15:0] rd_value_a;
   logic [15:0] rd_value_b;
   logic        rd_ready_a;
   logic        rd_ready_b;
`endif

   typedef struct {
      logic [2:0]  tag;
      logic [2:0]  dest;
      logic [15:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   reorder_buffer #(.data_width(16), .tag_width(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alloc_req     (alloc_req),
      .alloc_opcode  (alloc_opcode),
      .alloc_dest    (alloc_dest),
      .alloc_predict (alloc_predict),
      .alloc_addr    (alloc_addr),
      .full          (full),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .cdb_value     (cdb_value),
      .head_valid    (head_valid),
      .head_opcode   (head_opcode),
      .head_dest     (head_dest),
      .head_value    (head_value),
      .head_predict  (head_predict),
      .head_addr     (head_addr),
      .empty         (empty),
      .RE            (RE),
      .flush         (flush)
`ifdef ROB_FWD_EN
      ,
      .rd_tag_a      (rd_tag_a),
      .rd_tag_b      (rd_tag_b),
      .rd_value_a    (rd_value_a),
      .rd_value_b    (rd_value_b),
      .rd_ready_a    (rd_ready_a),
      .rd_ready_b    (rd_ready_b)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      alloc_req     = 1'b0;
      alloc_predict = 1'b0;
      RE            = 1'b0;
      cdb_valid     = 1'b0;
      flush         = 1'b0;
   endtask

   task automatic set_alloc(input logic [2:0] dest, input lc3b_opcode op, input logic pred);
      alloc_req     = 1'b1;
      alloc_dest    = dest;
      alloc_opcode  = op;
      alloc_predict = pred;
   endtask

   task automatic set_cdb(input logic [2:0] tag, input logic [15:0] value);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
      cdb_value = value;
   endtask

   // Commit monitor: every head retired while valid is matched against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && RE && head_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_commit: got tag %0h expected no commit", head_addr);
         end else begin
            e = exp_q.pop_front();
            chk("commit_tag", 32'(head_addr), 32'(e.tag));
            chk("commit_dest", 32'(head_dest), 32'(e.dest));
            chk("commit_value", 32'(head_value), 32'(e.value));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      alloc_req = 1'b0; alloc_opcode = op_br; alloc_dest = '0; alloc_predict = 1'b0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
      RE = 1'b0; flush = 1'b0;
`ifdef ROB_FWD_EN
      rd_tag_a = '0; rd_tag_b = '0;
`endif
      #3;
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_head_valid", 32'(head_valid), 0);
      chk("rst_alloc_addr", 32'(alloc_addr), 0);
      chk("rst_head_addr", 32'(head_addr), 0);
      chk("rst_head_value", 32'(head_value), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // three allocations get tags 0,1,2
      for (int i = 0; i < 3; i++) begin
         chk("alloc_addr_seq", 32'(alloc_addr), 32'(i));
         set_alloc(3'(i + 1), op_add, 1'b0);
         tick();
      end
      chk("count_3", 32'(dut.count), 3);
      chk("not_empty", 32'(empty), 0);
      chk("head_not_ready", 32'(head_valid), 0);

      // out-of-order completion, in-order commit
      set_cdb(3'd1, 16'h1234); tick();
      chk("head_wait_tag0", 32'(head_valid), 0);
      set_cdb(3'd0, 16'h0042); tick();
      chk("head_valid_tag0", 32'(head_valid), 1);
      chk("head_value_tag0", 32'(head_value), 16'h0042);
      exp_q.push_back('{3'd0, 3'd1, 16'h0042});
      RE = 1'b1; tick();
      chk("head_valid_tag1", 32'(head_valid), 1);
      exp_q.push_back('{3'd1, 3'd2, 16'h1234});
      RE = 1'b1; tick();
      chk("head_tag2_unready", 32'(head_valid), 0);
      RE = 1'b1; tick();
      chk("empty_after_pops", 32'(empty), 1);
      chk("count_0", 32'(dut.count), 0);

      // CDB to an unoccupied slot is ignored
      set_cdb(3'd5, 16'h5555); tick();
      chk("empty_after_stray_cdb", 32'(empty), 1);
      for (int i = 0; i < 3; i++) begin
         set_alloc(3'd0, op_add, 1'b0); tick();
      end
      RE = 1'b1; tick();
      RE = 1'b1; tick();
      chk("head_at_5", 32'(head_addr), 5);
      chk("tag5_not_ready", 32'(head_valid), 0);
      chk("tag5_value_clear", 32'(head_value), 0);
      set_alloc(3'd0, op_add, 1'b0); tick();
      RE = 1'b1; tick();
      RE = 1'b1; tick();
      chk("empty_at_7", 32'(empty), 1);
      chk("tail_at_7", 32'(alloc_addr), 7);

      // fill from tag 7 around the wrap
      for (int i = 0; i < 8; i++) begin
         chk("fill_alloc_addr", 32'(alloc_addr), 32'((7 + i) % 8));
         set_alloc(3'((7 + i) % 8), op_ldr, 1'b0);
         tick();
      end
      chk("full_set", 32'(full), 1);
      chk("count_8", 32'(dut.count), 8);
      chk("full_tail", 32'(alloc_addr), 7);
      set_cdb(3'd7, 16'h0707); tick();
      chk("head7_valid", 32'(head_valid), 1);
      exp_q.push_back('{3'd7, 3'd7, 16'h0707});
      set_alloc(3'd1, op_add, 1'b0); RE = 1'b1; tick();
      chk("full_alloc_dropped", 32'(dut.count), 7);
      chk("full_cleared", 32'(full), 0);
      chk("tail_unmoved", 32'(alloc_addr), 7);
      chk("head_wrapped", 32'(head_addr), 0);
      set_alloc(3'd1, op_add, 1'b0); RE = 1'b1; tick();
      chk("alloc_pop_count", 32'(dut.count), 7);
      chk("tail_wrapped", 32'(alloc_addr), 0);
      chk("head_at_1", 32'(head_addr), 1);
      RE = 1'b1; tick();
      RE = 1'b1; tick();
      chk("count_5", 32'(dut.count), 5);

      // flush beats same-cycle alloc and CDB
      flush = 1'b1; set_alloc(3'd4, op_add, 1'b0); set_cdb(3'd3, 16'h9999); tick();
      chk("flush_empty", 32'(empty), 1);
      chk("flush_alloc_addr", 32'(alloc_addr), 0);
      chk("flush_head_valid", 32'(head_valid), 0);
      chk("flush_head_addr", 32'(head_addr), 0);
      chk("flush_count", 32'(dut.count), 0);

      // pop wins over a CDB write to the head
      set_alloc(3'd5, op_add, 1'b1); tick();
      set_alloc(3'd6, op_not, 1'b0); tick();
      set_cdb(3'd0, 16'hABCD); tick();
      chk("head_valid_post_flush", 32'(head_valid), 1);
      chk("head_predict", 32'(head_predict), 1);
      chk("head_opcode", 32'(head_opcode), 32'(op_add));
      exp_q.push_back('{3'd0, 3'd5, 16'hABCD});
      RE = 1'b1; set_cdb(3'd0, 16'hFFFF); tick();
      chk("head_at_1_post", 32'(head_addr), 1);
      chk("head1_unready", 32'(head_valid), 0);
      chk("count_1", 32'(dut.count), 1);

      // operand lookup and bypass on tag 2
      set_alloc(3'd7, op_ldb, 1'b0); tick();
      set_cdb(3'd2, 16'hBEEF);
`ifdef ROB_FWD_EN
      rd_tag_a = 3'd2;
      rd_tag_b = 3'd1;
      #1;
      chk("bypass_ready_a", 32'(rd_ready_a), 1);
      chk("bypass_value_a", 32'(rd_value_a), 16'hBEEF);
      chk("lookup_ready_b", 32'(rd_ready_b), 0);
`endif
      tick();
`ifdef ROB_FWD_EN
      chk("stored_ready_a", 32'(rd_ready_a), 1);
      chk("stored_value_a", 32'(rd_value_a), 16'hBEEF);
`endif
      chk("head1_still_unready", 32'(head_valid), 0);
      chk("count_2", 32'(dut.count), 2);

      // asynchronous reset mid-operation
      rst_n = 1'b0;
      #1;
      chk("arst_empty", 32'(empty), 1);
      chk("arst_full", 32'(full), 0);
      chk("arst_head_valid", 32'(head_valid), 0);
      chk("arst_alloc_addr", 32'(alloc_addr), 0);
      chk("arst_head_addr", 32'(head_addr), 0);
      chk("arst_head_dest", 32'(head_dest), 0);
      chk("arst_head_opcode", 32'(head_opcode), 0);
`ifdef ROB_FWD_EN
      chk("arst_rd_ready_a", 32'(rd_ready_a), 0);
      chk("arst_rd_value_a", 32'(rd_value_a), 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      chk("post_reset_empty", 32'(empty), 1);
      chk("queue_drained", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
